max_pool_stream: RTL and testbench

//  Parametrised streaming KxK max-pooling, stride K, over a raster-order feature map.

---
 rtl/max_pool_stream_pkg.sv | 33 +++
 rtl/max_pool_stream_chan.sv | 81 ++++++++
 rtl/max_pool_stream.sv | 156 +++++++++++++++
 tb/tb_max_pool_stream.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/max_pool_stream_pkg.sv
// ---------------------------------------------------------------------------
// max_pool_stream_pkg
// Shared definitions for the streaming KxK max-pooling block:
//   - default geometry/width parameters
//   - row_phase_t: what the row buffer does when a horizontal window closes
//   - out_dim / idx_w: helpers for the pooled size and counter widths
// ---------------------------------------------------------------------------
package max_pool_stream_pkg;

    localparam int DEF_CH      = 3;
    localparam int DEF_DATA_BW = 32;
    localparam int DEF_IMG_W   = 12;
    localparam int DEF_IMG_H   = 12;
    localparam int DEF_POOL_K  = 2;

    // Role of the current input row inside a pooling window.
    typedef enum logic [1:0] {
        ROW_FIRST = 2'd0,   // first row: overwrite the row buffer entry
        ROW_MID   = 2'd1,   // middle row: fold into the row buffer entry
        ROW_LAST  = 2'd2    // last row: produce the pooled result
    } row_phase_t;

    // Pooled dimension; ragged remainders are dropped.
    function automatic int out_dim(input int img, input int k);
        return img / k;
    endfunction

    // Index width able to address n entries (at least one bit).
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/max_pool_stream_chan.sv
// ---------------------------------------------------------------------------
// max_pool_stream_chan
// One channel of the max-pooling datapath: horizontal running max (hmax),
// the channel's slice of the partial-maxima row buffer and the result reg.
// Ports:
//   clk, reset_n  clock / synchronous active-high reset
//   beat          input beat valid
//   first_col     beat is the first column of a horizontal window
//   col_done      beat closes a horizontal window inside the pooled area
//   row_phase     role of the current row inside the vertical window
//   addr          output-column index (row buffer entry)
//   din           channel sample
//   dout          pooled maximum, updated when a full window closes
// ---------------------------------------------------------------------------
module max_pool_stream_chan
    import max_pool_stream_pkg::*;
#(
    parameter int DATA_BW = DEF_DATA_BW,
    parameter int OUT_W   = 6,
    parameter int AW      = 3,
    parameter int SIGNED  = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               beat,
    input  logic               first_col,
    input  logic               col_done,
    input  row_phase_t         row_phase,
    input  logic [AW-1:0]      addr,
    input  logic [DATA_BW-1:0] din,
    output logic [DATA_BW-1:0] dout
);

    // Ties keep the first operand, so the earlier sample wins on equality.
    function automatic logic [DATA_BW-1:0] max2(input logic [DATA_BW-1:0] a,
                                                input logic [DATA_BW-1:0] b);
        logic gt;
        if (SIGNED != 0) gt = ($signed(b) > $signed(a));
        else             gt = (b > a);
        return gt ? b : a;
    endfunction

    logic [DATA_BW-1:0] rbuf [OUT_W];
    logic [DATA_BW-1:0] hmax;
    logic [DATA_BW-1:0] hv;
    logic [DATA_BW-1:0] rd;

    assign hv = max2(hmax, din);
    assign rd = rbuf[addr];

    // Horizontal running max, restarted at the first column of each window.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            hmax <= '0;
        end else if (beat) begin
            hmax <= first_col ? din : hv;
        end
    end

    // Row buffer has no reset: the first row of every window overwrites its
    // entry before it is ever read, so stale contents never reach dout.
    always_ff @(posedge clk) begin
        if (!reset_n && col_done) begin
            case (row_phase)
                ROW_FIRST: rbuf[addr] <= hv;
                ROW_MID:   rbuf[addr] <= max2(rd, hv);
                default:   ;
            endcase
        end
    end

    // Pooled result for the window that closes on this beat.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            dout <= '0;
        end else if (col_done && (row_phase == ROW_LAST)) begin
            dout <= max2(rd, hv);
        end
    end

endmodule

// File: rtl/max_pool_stream.sv
// ---------------------------------------------------------------------------
// max_pool_stream
// Streaming KxK / stride-K max pooling over a raster-order feature map,
// CH channels in lockstep. Keeps one row of partial maxima per channel.
// Ports:
//   clk        rising-edge clock
//   reset_n    synchronous reset, ACTIVE-HIGH despite the name
//   i_sof      with i_valid: beat is pixel (0,0), realigns the counters
//   i_valid    input beat valid (no backpressure)
//   i_data     channel c at [c*DATA_BW +: DATA_BW]
//   o_valid    single-cycle pooled beat valid, 1 clk after the closing beat
//   o_data     pooled maxima, same packing as i_data
//   o_last     with o_valid: last pooled pixel of the frame
//   o_sof_err  1-cycle pulse: i_sof arrived while not at (0,0)
// POOL_K must be 2..4 and IMG_W, IMG_H must be at least POOL_K.
// ---------------------------------------------------------------------------
module max_pool_stream
    import max_pool_stream_pkg::*;
#(
    parameter int CH      = DEF_CH,
    parameter int DATA_BW = DEF_DATA_BW,
    parameter int IMG_W   = DEF_IMG_W,
    parameter int IMG_H   = DEF_IMG_H,
    parameter int POOL_K  = DEF_POOL_K,
    parameter int SIGNED  = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_sof,
    input  logic                  i_valid,
    input  logic [CH*DATA_BW-1:0] i_data,
    output logic                  o_valid,
    output logic [CH*DATA_BW-1:0] o_data,
    output logic                  o_last,
    output logic                  o_sof_err
);

    localparam int OUT_W = out_dim(IMG_W, POOL_K);
    localparam int OUT_H = out_dim(IMG_H, POOL_K);
    localparam int CW    = idx_w(IMG_W);
    localparam int RW    = idx_w(IMG_H);
    localparam int KW    = idx_w(POOL_K);
    localparam int OCW   = idx_w(OUT_W + 1);
    localparam int AW    = idx_w(OUT_W);

    localparam logic [CW-1:0] COL_MAX  = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_USED = CW'(OUT_W * POOL_K - 1);
    localparam logic [RW-1:0] ROW_MAX  = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_USED = RW'(OUT_H * POOL_K - 1);
    localparam logic [KW-1:0] K_MAX    = KW'(POOL_K - 1);

    logic [CW-1:0]  col, cur_col;
    logic [RW-1:0]  row, cur_row;
    logic [KW-1:0]  kc, cur_kc;
    logic [KW-1:0]  kr, cur_kr;
    logic [OCW-1:0] oc, cur_oc;

    logic       col_wrap, row_wrap, kc_wrap, kr_wrap;
    logic       in_win, col_done, emit, sof_err, kc_first;
    row_phase_t row_phase;

    // An i_sof beat is treated as pixel (0,0) regardless of where the
    // counters were, so everything downstream works on the forced position.
    always_comb begin
        cur_col = col;
        cur_row = row;
        cur_kc  = kc;
        cur_kr  = kr;
        cur_oc  = oc;
        if (i_sof) begin
            cur_col = '0;
            cur_row = '0;
            cur_kc  = '0;
            cur_kr  = '0;
            cur_oc  = '0;
        end
    end

    assign col_wrap = (cur_col == COL_MAX);
    assign row_wrap = (cur_row == ROW_MAX);
    assign kc_wrap  = (cur_kc == K_MAX);
    assign kr_wrap  = (cur_kr == K_MAX);
    assign kc_first = (cur_kc == '0);

    // Ragged right columns / bottom rows are counted but never pooled.
    assign in_win   = (cur_col <= COL_USED) && (cur_row <= ROW_USED);
    assign col_done = i_valid && in_win && kc_wrap;
    assign emit     = col_done && kr_wrap;
    assign sof_err  = i_valid && i_sof && ((col != '0) || (row != '0));

    // Row role inside the vertical window.
    always_comb begin
        row_phase = ROW_MID;
        if (cur_kr == '0) row_phase = ROW_FIRST;
        else if (kr_wrap) row_phase = ROW_LAST;
    end

    // Raster counters plus window-local kc/kr and the output column oc.
    // kc restarts at every new row so ragged widths cannot skew windows.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            col <= '0;
            row <= '0;
            kc  <= '0;
            kr  <= '0;
            oc  <= '0;
        end else if (i_valid) begin
            if (col_wrap) begin
                col <= '0;
                kc  <= '0;
                oc  <= '0;
                row <= row_wrap ? '0 : cur_row + RW'(1);
                kr  <= (row_wrap || kr_wrap) ? '0 : cur_kr + KW'(1);
            end else begin
                col <= cur_col + CW'(1);
                kc  <= kc_wrap ? '0 : cur_kc + KW'(1);
                oc  <= kc_wrap ? cur_oc + OCW'(1) : cur_oc;
                row <= cur_row;
                kr  <= cur_kr;
            end
        end
    end

    // Output strobes, registered alongside the channel result registers.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            o_valid   <= 1'b0;
            o_last    <= 1'b0;
            o_sof_err <= 1'b0;
        end else begin
            o_valid   <= emit;
            o_last    <= emit && (cur_col == COL_USED) && (cur_row == ROW_USED);
            o_sof_err <= sof_err;
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_chan
        max_pool_stream_chan #(
            .DATA_BW (DATA_BW),
            .OUT_W   (OUT_W),
            .AW      (AW),
            .SIGNED  (SIGNED)
        ) u_chan (
            .clk       (clk),
            .reset_n   (reset_n),
            .beat      (i_valid),
            .first_col (kc_first),
            .col_done  (col_done),
            .row_phase (row_phase),
            .addr      (cur_oc[AW-1:0]),
            .din       (i_data[c*DATA_BW +: DATA_BW]),
            .dout      (o_data[c*DATA_BW +: DATA_BW])
        );
    end

endmodule

// File: tb/tb_max_pool_stream.sv
// ---------------------------------------------------------------------------
// tb_max_pool_stream
// Four instances: signed and unsigned 12x12 K=2 sharing one input port,
// a 12x12 K=3 instance and a 5x5 K=2 instance. Expected outputs come from
// a direct 2-D window-max model of the frame image.
// ---------------------------------------------------------------------------
module tb_max_pool_stream;

    typedef struct {
        logic [95:0] data;
        logic        last;
        int          cyc;
    } out_t;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0]       isof = '0;
    logic [2:0]       ival = '0;
    logic [2:0][95:0] idat = '0;
    logic [3:0]       ov, ol, oe;
    logic [3:0][95:0] od;

    out_t        obq [4][$];
    out_t        exq [4][$];
    int          ob_rd [4];
    int          ex_rd [4];
    int          errcnt [4];
    int          errcyc [4];
    logic [95:0] img [144];
    int          beat_cyc [144];
    int          checks = 0;
    int          failures = 0;

    max_pool_stream #(.SIGNED(1)) dut (
        .clk(clk), .reset_n(reset_n), .i_sof(isof[0]), .i_valid(ival[0]), .i_data(idat[0]),
        .o_valid(ov[0]), .o_data(od[0]), .o_last(ol[0]), .o_sof_err(oe[0]));

    max_pool_stream #(.SIGNED(0)) dut_u (
        .clk(clk), .reset_n(reset_n), .i_sof(isof[0]), .i_valid(ival[0]), .i_data(idat[0]),
        .o_valid(ov[1]), .o_data(od[1]), .o_last(ol[1]), .o_sof_err(oe[1]));

    max_pool_stream #(.POOL_K(3)) dut_k3 (
        .clk(clk), .reset_n(reset_n), .i_sof(isof[1]), .i_valid(ival[1]), .i_data(idat[1]),
        .o_valid(ov[2]), .o_data(od[2]), .o_last(ol[2]), .o_sof_err(oe[2]));

    max_pool_stream #(.IMG_W(5), .IMG_H(5)) dut_s (
        .clk(clk), .reset_n(reset_n), .i_sof(isof[2]), .i_valid(ival[2]), .i_data(idat[2]),
        .o_valid(ov[3]), .o_data(od[3]), .o_last(ol[3]), .o_sof_err(oe[3]));

    // Output monitor: records every pooled beat and sof error pulse.
    always @(negedge clk) begin : mon
        out_t r;
        for (int i = 0; i < 4; i++) begin
            if (ov[i] === 1'b1) begin
                r.data = od[i];
                r.last = ol[i];
                r.cyc  = cyc;
                obq[i].push_back(r);
            end
            if (oe[i] === 1'b1) begin
                errcnt[i] = errcnt[i] + 1;
                errcyc[i] = cyc;
            end
        end
    end

    task automatic applyStimulus(input int port, input logic sof, input logic valid,
                                 input logic [95:0] data);
        @(negedge clk);
        ival = '0;
        isof = '0;
        ival[port] = valid;
        isof[port] = sof;
        idat[port] = data;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(0, 1'b0, 1'b0, '0);
    endtask

    task automatic driveFrame(input int port, input int nbeats, input bit sof_first,
                              input bit gaps);
        for (int i = 0; i < nbeats; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) applyStimulus(port, 1'b0, 1'b0, '0);
            applyStimulus(port, logic'((i == 0) && sof_first), 1'b1, img[i]);
            beat_cyc[i] = cyc;
        end
    endtask

    task automatic fillRamp(input int n);
        for (int i = 0; i < n; i++) img[i] = {3{32'(i)}};
    endtask

    // Reference: every window whose bottom-right pixel was fed produces
    // the per-channel max of its KxK pixels, one cycle after that pixel.
    task automatic buildExpected(input int inst, input int w, input int h, input int k,
                                 input bit sgn, input int nbeats);
        out_t        e;
        logic [31:0] best, v;
        int          comp;
        for (int oy = 0; oy < h / k; oy++) begin
            for (int ox = 0; ox < w / k; ox++) begin
                comp = (oy * k + k - 1) * w + ox * k + k - 1;
                if (comp < nbeats) begin
                    for (int c = 0; c < 3; c++) begin
                        best = img[oy * k * w + ox * k][c*32 +: 32];
                        for (int dy = 0; dy < k; dy++) begin
                            for (int dx = 0; dx < k; dx++) begin
                                v = img[(oy * k + dy) * w + ox * k + dx][c*32 +: 32];
                                if (sgn ? ($signed(v) > $signed(best)) : (v > best)) best = v;
                            end
                        end
                        e.data[c*32 +: 32] = best;
                    end
                    e.last = logic'((ox == w / k - 1) && (oy == h / k - 1));
                    e.cyc  = beat_cyc[comp] + 1;
                    exq[inst].push_back(e);
                end
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [95:0] got,
                               input logic [95:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic int obsCount(input int inst);
        return obq[inst].size() - ob_rd[inst];
    endfunction

    function automatic logic [95:0] obsData(input int inst, input int k);
        if (k >= 0 && ob_rd[inst] + k < obq[inst].size()) return obq[inst][ob_rd[inst] + k].data;
        return 'x;
    endfunction

    function automatic logic obsLast(input int inst, input int k);
        if (k >= 0 && ob_rd[inst] + k < obq[inst].size()) return obq[inst][ob_rd[inst] + k].last;
        return 1'bx;
    endfunction

    task automatic checkStream(input int inst, input string tag);
        int   nobs, nexp, n;
        out_t o, e;
        nobs = obsCount(inst);
        nexp = exq[inst].size() - ex_rd[inst];
        checkOutput($sformatf("%s_count", tag), 96'(nobs), 96'(nexp));
        n = (nobs < nexp) ? nobs : nexp;
        for (int j = 0; j < n; j++) begin
            o = obq[inst][ob_rd[inst] + j];
            e = exq[inst][ex_rd[inst] + j];
            checkOutput($sformatf("%s_data%0d", tag, j), o.data, e.data);
            checkOutput($sformatf("%s_last%0d", tag, j), 96'(o.last), 96'(e.last));
            checkOutput($sformatf("%s_cyc%0d", tag, j), 96'(o.cyc), 96'(e.cyc));
        end
        ob_rd[inst] = obq[inst].size();
        ex_rd[inst] = exq[inst].size();
    endtask

    initial begin
        int e0, e1;

        // Reset state
        reset_n = 1'b1;
        idle(3);
        checkOutput("rst_valid", 96'(ov), '0);
        checkOutput("rst_data", od[0], '0);
        checkOutput("rst_last", 96'(ol), '0);
        checkOutput("rst_sof_err", 96'(oe), '0);
        reset_n = 1'b0;

        // 12x12 ramp, contiguous
        fillRamp(144);
        driveFrame(0, 144, 1'b1, 1'b0);
        idle(3);
        buildExpected(0, 12, 12, 2, 1'b1, 144);
        buildExpected(1, 12, 12, 2, 1'b0, 144);
        checkOutput("t1_n", 96'(obsCount(0)), 96'd36);
        checkOutput("t1_first", obsData(0, 0), {3{32'd13}});
        checkOutput("t1_lastval", obsData(0, 35), {3{32'd143}});
        checkOutput("t1_lastflag", 96'(obsLast(0, 35)), 96'd1);
        checkOutput("t1_no_sof_err", 96'(errcnt[0]), 96'd0);
        checkStream(0, "t1s");
        checkStream(1, "t1u");

        // Random full-range data with directed negative windows
        for (int i = 0; i < 144; i++) img[i] = {$urandom, $urandom, $urandom};
        img[0]  = {3{32'hFFFF_FFFB}};
        img[1]  = {3{32'hFFFF_FFFE}};
        img[12] = {3{32'hFFFF_FFF7}};
        img[13] = {3{32'hFFFF_FFFF}};
        img[2]  = {3{32'hFFFF_FFFD}};
        img[3]  = {3{32'd5}};
        img[14] = {3{32'd7}};
        img[15] = {3{32'hFFFF_FFF8}};
        driveFrame(0, 144, 1'b1, 1'b0);
        idle(3);
        buildExpected(0, 12, 12, 2, 1'b1, 144);
        buildExpected(1, 12, 12, 2, 1'b0, 144);
        checkOutput("t2_signed_w0", obsData(0, 0), {3{32'hFFFF_FFFF}});
        checkOutput("t2_unsigned_w0", obsData(1, 0), {3{32'hFFFF_FFFF}});
        checkOutput("t2_signed_w1", obsData(0, 1), {3{32'd7}});
        checkOutput("t2_unsigned_w1", obsData(1, 1), {3{32'hFFFF_FFFD}});
        checkStream(0, "t2s");
        checkStream(1, "t2u");

        // 5x5 ragged frame
        fillRamp(25);
        driveFrame(2, 25, 1'b1, 1'b0);
        idle(3);
        buildExpected(3, 5, 5, 2, 1'b1, 25);
        checkOutput("t3_n", 96'(obsCount(3)), 96'd4);
        checkOutput("t3_o0", obsData(3, 0), {3{32'd6}});
        checkOutput("t3_o1", obsData(3, 1), {3{32'd8}});
        checkOutput("t3_o2", obsData(3, 2), {3{32'd16}});
        checkOutput("t3_o3", obsData(3, 3), {3{32'd18}});
        checkOutput("t3_lastflag", 96'(obsLast(3, 3)), 96'd1);
        checkStream(3, "t3");

        // Ramp with random valid gaps
        fillRamp(144);
        driveFrame(0, 144, 1'b1, 1'b1);
        idle(3);
        buildExpected(0, 12, 12, 2, 1'b1, 144);
        buildExpected(1, 12, 12, 2, 1'b0, 144);
        checkStream(0, "t4s");
        checkStream(1, "t4u");

        // Reset after 30 beats of large values, then a frame without i_sof
        for (int i = 0; i < 144; i++) img[i] = {3{32'h7FFF_FFFF}};
        driveFrame(0, 30, 1'b1, 1'b0);
        buildExpected(0, 12, 12, 2, 1'b1, 30);
        buildExpected(1, 12, 12, 2, 1'b0, 30);
        idle(1);
        reset_n = 1'b1;
        idle(1);
        reset_n = 1'b0;
        e0 = errcnt[0];
        fillRamp(144);
        driveFrame(0, 144, 1'b0, 1'b0);
        idle(3);
        buildExpected(0, 12, 12, 2, 1'b1, 144);
        buildExpected(1, 12, 12, 2, 1'b0, 144);
        checkOutput("t5_no_sof_err", 96'(errcnt[0] - e0), 96'd0);
        checkStream(0, "t5s");
        checkStream(1, "t5u");

        // i_sof arriving at beat 20 of a frame
        fillRamp(144);
        driveFrame(0, 20, 1'b1, 1'b0);
        buildExpected(0, 12, 12, 2, 1'b1, 20);
        buildExpected(1, 12, 12, 2, 1'b0, 20);
        e0 = errcnt[0];
        e1 = errcnt[1];
        driveFrame(0, 144, 1'b1, 1'b0);
        idle(3);
        buildExpected(0, 12, 12, 2, 1'b1, 144);
        buildExpected(1, 12, 12, 2, 1'b0, 144);
        checkOutput("t6_err_n", 96'(errcnt[0] - e0), 96'd1);
        checkOutput("t6_err_cyc", 96'(errcyc[0]), 96'(beat_cyc[0] + 1));
        checkOutput("t6_err_n_u", 96'(errcnt[1] - e1), 96'd1);
        checkStream(0, "t6s");
        checkStream(1, "t6u");

        // K=3 ramp
        fillRamp(144);
        driveFrame(1, 144, 1'b1, 1'b0);
        idle(3);
        buildExpected(2, 12, 12, 3, 1'b1, 144);
        checkOutput("t7_n", 96'(obsCount(2)), 96'd16);
        checkOutput("t7_first", obsData(2, 0), {3{32'd26}});
        checkOutput("t7_lastval", obsData(2, 15), {3{32'd143}});
        checkStream(2, "t7");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
